// File: rtl/sdram_arb_pkg.sv
// Shared constants and types for the SDRAM slot arbiter.
// Slot timing is fixed at eight clocks; the grant and completion phases are named here.
package sdram_arb_pkg;

  localparam int PHASE_W = 3;
  localparam int ADDR_W  = 22;
  localparam int DATA_W  = 16;

  localparam logic [PHASE_W-1:0] PH_GRANT = 3'd1;
  localparam logic [PHASE_W-1:0] PH_DONE  = 3'd7;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_CPU,
    GNT_VID
  } grant_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY_CPU,
    ST_BUSY_VID
  } slot_state_e;

  // Width of a counter that must hold values 0..max_slots inclusive.
  function automatic int slot_cnt_width(input int max_slots);
    return $clog2(max_slots + 1);
  endfunction

endpackage

// File: rtl/sdram_arbiter.sv
// Two-port (CPU / video) slot arbiter in front of the SDRAM controller.
// One access per 8-cycle slot, with a forced idle slot for auto-refresh.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int REFRESH_MAX = 48
) (
  input  logic               clk,
  input  logic               reset_n,

  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_din,
  input  logic [1:0]         cpu_ds,
  output logic               cpu_ack,
  output logic [DATA_W-1:0]  cpu_rdata,

  input  logic               vid_req,
  input  logic [ADDR_W-1:0]  vid_addr,
  output logic               vid_ack,
  output logic [DATA_W-1:0]  vid_rdata,

  input  logic               mem_ready,
  output logic [PHASE_W-1:0] mem_phase,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_din,
  output logic [1:0]         mem_ds,
  output logic               mem_oe,
  output logic               mem_we,
  input  logic [DATA_W-1:0]  mem_dout
);

  localparam int                CNT_W   = slot_cnt_width(REFRESH_MAX);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(REFRESH_MAX);

  slot_state_e      state;
  grant_e           last_grant;
  logic [CNT_W-1:0] slot_cnt;

  grant_e grant;
  logic   cpu_pending;
  logic   vid_pending;
  logic   contested;
  logic   refresh_due;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cpu_pending = cpu_req && !cpu_ack;
    vid_pending = vid_req && !vid_ack;
    contested   = cpu_pending && vid_pending;
    refresh_due = (slot_cnt == CNT_MAX);
    grant       = GNT_NONE;
    if (mem_ready && !refresh_due) begin
      if (contested)
        grant = (last_grant == GNT_CPU) ? GNT_VID : GNT_CPU;
      else if (cpu_pending)
        grant = GNT_CPU;
      else if (vid_pending)
        grant = GNT_VID;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_phase  <= '0;
      state      <= ST_IDLE;
      last_grant <= GNT_CPU;
      slot_cnt   <= '0;
      mem_addr   <= '0;
      mem_din    <= '0;
      mem_ds     <= 2'b11;
      mem_oe     <= 1'b0;
      mem_we     <= 1'b0;
      cpu_ack    <= 1'b0;
      vid_ack    <= 1'b0;
      cpu_rdata  <= '0;
      vid_rdata  <= '0;
    end else begin
      mem_phase <= mem_phase + PHASE_W'(1);
      cpu_ack   <= 1'b0;
      vid_ack   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (mem_phase == PH_GRANT) begin
            case (grant)
              GNT_CPU: begin
                state    <= ST_BUSY_CPU;
                mem_addr <= cpu_addr;
                mem_din  <= cpu_din;
                mem_ds   <= cpu_ds;
                mem_oe   <= !cpu_we;
                mem_we   <= cpu_we;
              end
              GNT_VID: begin
                // Video always fetches the full word.
                state    <= ST_BUSY_VID;
                mem_addr <= vid_addr;
                mem_ds   <= 2'b00;
                mem_oe   <= 1'b1;
                mem_we   <= 1'b0;
              end
              default: begin
                mem_oe <= 1'b0;
                mem_we <= 1'b0;
              end
            endcase
            // An ungranted slot (including the forced one) is what lets the controller refresh.
            slot_cnt <= (grant == GNT_NONE) ? '0 : slot_cnt + CNT_W'(1);
            if (contested && grant != GNT_NONE)
              last_grant <= grant;
          end
        end

        ST_BUSY_CPU: begin
          if (mem_phase == PH_DONE) begin
            state   <= ST_IDLE;
            mem_oe  <= 1'b0;
            mem_we  <= 1'b0;
            cpu_ack <= 1'b1;
            if (!mem_we)
              cpu_rdata <= mem_dout;
          end
        end

        ST_BUSY_VID: begin
          if (mem_phase == PH_DONE) begin
            state     <= ST_IDLE;
            mem_oe    <= 1'b0;
            mem_we    <= 1'b0;
            vid_ack   <= 1'b1;
            vid_rdata <= mem_dout;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: a slot-level reference model predicts
// every output each cycle; scenario tasks add targeted checks from the slot rules.
module tb_sdram_arbiter;

  localparam int REFRESH_MAX = 48;

  logic        clk;
  logic        reset_n;
  logic        cpu_req, cpu_we;
  logic [21:0] cpu_addr;
  logic [15:0] cpu_din;
  logic [1:0]  cpu_ds;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        vid_req;
  logic [21:0] vid_addr;
  logic        vid_ack;
  logic [15:0] vid_rdata;
  logic        mem_ready;
  logic [2:0]  mem_phase;
  logic [21:0] mem_addr;
  logic [15:0] mem_din;
  logic [1:0]  mem_ds;
  logic        mem_oe, mem_we;
  logic [15:0] mem_dout;

  logic        use_fixed;
  logic [15:0] fixed_dout;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  sdram_arbiter #(.REFRESH_MAX(REFRESH_MAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ds(cpu_ds), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .mem_ready(mem_ready), .mem_phase(mem_phase), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_ds(mem_ds), .mem_oe(mem_oe), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  initial begin
    clk = 1'b0;
    forever #16 clk = ~clk;
  end

  // Stand-in for the SDRAM: read data is a fixed scramble of the address.
  function automatic logic [15:0] data_fn(input logic [21:0] a);
    return a[15:0] ^ {a[21:16], 10'h2A5};
  endfunction

  assign mem_dout = use_fixed ? fixed_dout : data_fn(mem_addr);

  typedef struct packed {
    logic [2:0]  phase;
    logic [21:0] addr;
    logic [15:0] din;
    logic [1:0]  ds;
    logic        oe;
    logic        we;
    logic        cack;
    logic        vack;
    logic [15:0] crd;
    logic [15:0] vrd;
  } obs_t;

  // ---------------- reference model (slot level) ----------------
  int          m_phase;
  int          m_gnt;      // 0 none, 1 cpu, 2 video
  bit          m_last_cpu; // winner of the last contested slot was the CPU
  int          m_run;      // consecutive granted slots
  logic [21:0] m_addr;
  logic [15:0] m_din;
  logic [1:0]  m_ds;
  logic        m_oe, m_we, m_cack, m_vack;
  logic [15:0] m_crd, m_vrd;

  function automatic void model_reset();
    m_phase = 0; m_gnt = 0; m_last_cpu = 1'b1; m_run = 0;
    m_addr = '0; m_din = '0; m_ds = 2'b11; m_oe = 1'b0; m_we = 1'b0;
    m_cack = 1'b0; m_vack = 1'b0; m_crd = '0; m_vrd = '0;
  endfunction

  // Advance the model across one clock edge using the inputs present before it.
  function automatic void model_edge();
    logic [15:0] rd;
    int g;
    if (!reset_n) begin
      model_reset();
      return;
    end
    m_cack = 1'b0;
    m_vack = 1'b0;
    if (m_phase == 1) begin
      if (m_run == REFRESH_MAX || !mem_ready || !(cpu_req || vid_req))
        g = 0;
      else if (cpu_req && vid_req) begin
        g = m_last_cpu ? 2 : 1;
        m_last_cpu = (g == 1);
      end else
        g = cpu_req ? 1 : 2;
      m_run = (g == 0) ? 0 : m_run + 1;
      m_gnt = g;
      if (g == 1) begin
        m_addr = cpu_addr; m_din = cpu_din; m_ds = cpu_ds;
        m_we = cpu_we; m_oe = !cpu_we;
      end else if (g == 2) begin
        m_addr = vid_addr; m_ds = 2'b00; m_oe = 1'b1; m_we = 1'b0;
      end
    end else if (m_phase == 7) begin
      rd = use_fixed ? fixed_dout : data_fn(m_addr);
      if (m_gnt == 1) begin
        m_cack = 1'b1;
        if (!m_we) m_crd = rd;
      end
      if (m_gnt == 2) begin
        m_vack = 1'b1;
        m_vrd = rd;
      end
      m_oe = 1'b0; m_we = 1'b0; m_gnt = 0;
    end
    m_phase = (m_phase + 1) % 8;
  endfunction

  function automatic obs_t ref_obs();
    obs_t e;
    e.phase = 3'(m_phase); e.addr = m_addr; e.din = m_din; e.ds = m_ds;
    e.oe = m_oe; e.we = m_we; e.cack = m_cack; e.vack = m_vack;
    e.crd = m_crd; e.vrd = m_vrd;
    return e;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.phase = mem_phase; o.addr = mem_addr; o.din = mem_din; o.ds = mem_ds;
    o.oe = mem_oe; o.we = mem_we; o.cack = cpu_ack; o.vack = vid_ack;
    o.crd = cpu_rdata; o.vrd = vid_rdata;
    return o;
  endfunction

  function automatic obs_t reset_obs();
    obs_t r;
    r = '0;
    r.ds = 2'b11;
    return r;
  endfunction

  // One clock: model steps, DUT steps, then we sit on the falling edge to sample/drive.
  task automatic tick();
    model_edge();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic goto_phase(input int p);
    for (int i = 0; i < 8 && m_phase != p; i++) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    obs_t o, e;
    reset_n = 1'b0;
    repeat (3) begin
      tick();
      o = dut_obs();
      n_checks++;
      if (o !== reset_obs()) begin
        n_errors++;
        $display("FAIL reset_values got=%h want=%h", o, reset_obs());
      end
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      o = dut_obs(); e = ref_obs();
      n_checks++;
      if (o.phase !== 3'(k % 8) || o !== e) begin
        n_errors++;
        $display("FAIL phase_count cyc=%0d got=%h want=%h (phase want %0d)", cyc, o, e, k % 8);
      end
    end
  endtask

  task automatic test_cpu_read();
    obs_t o, e;
    int sample_cyc, ack_cyc, lat;
    goto_phase(0);
    use_fixed = 1'b1; fixed_dout = 16'hBEEF;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 22'h12345;
    cpu_din = 16'($urandom); cpu_ds = 2'b11;
    sample_cyc = -1; ack_cyc = -1;
    repeat (16) begin
      tick();
      o = dut_obs(); e = ref_obs();
      n_checks++;
      if (o !== e) begin
        n_errors++;
        $display("FAIL cpu_read_model cyc=%0d got=%h want=%h", cyc, o, e);
      end
      if (m_phase == 2 && sample_cyc < 0) sample_cyc = cyc;
      if (m_phase >= 2 && ack_cyc < 0) begin
        n_checks++;
        if (mem_oe !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 22'h12345) begin
          n_errors++;
          $display("FAIL cpu_read_req phase=%0d oe=%b we=%b addr=%h want oe=1 we=0 addr=012345",
                   m_phase, mem_oe, mem_we, mem_addr);
        end
      end
      if (cpu_ack === 1'b1 && ack_cyc < 0) ack_cyc = cyc;
      if (m_cack) cpu_req = 1'b0;
    end
    lat = (ack_cyc < 0) ? -1 : ack_cyc - sample_cyc + 1;
    n_checks++;
    if (lat != 7 || cpu_rdata !== 16'hBEEF) begin
      n_errors++;
      $display("FAIL cpu_read_done latency=%0d rdata=%h want latency=7 rdata=beef", lat, cpu_rdata);
    end
    use_fixed = 1'b0;
  endtask

  task automatic test_cpu_write();
    obs_t o, e;
    int acks;
    goto_phase(0);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_ds = 2'b10; cpu_din = 16'hA55A;
    cpu_addr = 22'($urandom);
    acks = 0;
    repeat (16) begin
      tick();
      o = dut_obs(); e = ref_obs();
      n_checks++;
      if (o !== e) begin
        n_errors++;
        $display("FAIL cpu_write_model cyc=%0d got=%h want=%h", cyc, o, e);
      end
      if (m_phase >= 2 && acks == 0) begin
        n_checks++;
        if (mem_we !== 1'b1 || mem_oe !== 1'b0 || mem_din !== 16'hA55A || mem_ds !== 2'b10) begin
          n_errors++;
          $display("FAIL cpu_write_req phase=%0d we=%b oe=%b din=%h ds=%b want we=1 oe=0 din=a55a ds=10",
                   m_phase, mem_we, mem_oe, mem_din, mem_ds);
        end
      end
      if (cpu_ack === 1'b1) acks++;
      if (m_cack) cpu_req = 1'b0;
    end
    n_checks++;
    if (acks != 1 || cpu_rdata !== 16'hBEEF) begin
      n_errors++;
      $display("FAIL cpu_write_done acks=%0d rdata=%h want acks=1 rdata=beef", acks, cpu_rdata);
    end
  endtask

  task automatic test_contested();
    obs_t o, e;
    int slot, c_start, v_start, lat;
    bit want_vid;
    do_reset();
    mem_ready = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = {1'b0, 21'($urandom)};
    vid_req = 1'b1; vid_addr = {1'b1, 21'($urandom)};
    slot = 0; c_start = -1; v_start = -1;
    repeat (64) begin
      tick();
      o = dut_obs(); e = ref_obs();
      n_checks++;
      if (o !== e) begin
        n_errors++;
        $display("FAIL contested_model cyc=%0d got=%h want=%h", cyc, o, e);
      end
      if (m_phase == 2) begin
        want_vid = (slot % 2 == 0);
        n_checks++;
        if (mem_oe !== 1'b1 || mem_addr[21] !== want_vid) begin
          n_errors++;
          $display("FAIL contested_order slot=%0d oe=%b vid=%b want oe=1 vid=%b",
                   slot, mem_oe, mem_addr[21], want_vid);
        end
        slot++;
        if (c_start < 0) c_start = cyc;
        if (v_start < 0) v_start = cyc;
      end
      if (cpu_ack === 1'b1 && c_start >= 0) begin
        lat = cyc - c_start + 1;
        n_checks++;
        if (lat > 15) begin
          n_errors++;
          $display("FAIL contested_cpu_wait latency=%0d want <=15", lat);
        end
        c_start = -1;
      end
      if (vid_ack === 1'b1 && v_start >= 0) begin
        lat = cyc - v_start + 1;
        n_checks++;
        if (lat > 15) begin
          n_errors++;
          $display("FAIL contested_vid_wait latency=%0d want <=15", lat);
        end
        v_start = -1;
      end
      if (m_cack) cpu_addr = {1'b0, 21'($urandom)};
      if (m_vack) vid_addr = {1'b1, 21'($urandom)};
    end
    cpu_req = 1'b0; vid_req = 1'b0;
  endtask

  task automatic test_refresh();
    obs_t o, e;
    int slot, acks;
    bit want_gnt;
    do_reset();
    cpu_req = 1'b0; vid_req = 1'b1; vid_addr = 22'($urandom);
    slot = 0; acks = 0;
    repeat (800) begin
      tick();
      o = dut_obs(); e = ref_obs();
      n_checks++;
      if (o !== e) begin
        n_errors++;
        $display("FAIL refresh_model cyc=%0d got=%h want=%h", cyc, o, e);
      end
      if (m_phase == 2) begin
        want_gnt = (slot % (REFRESH_MAX + 1)) != REFRESH_MAX;
        n_checks++;
        if ((mem_oe | mem_we) !== want_gnt) begin
          n_errors++;
          $display("FAIL refresh_slot slot=%0d granted=%b want %b", slot, mem_oe | mem_we, want_gnt);
        end
        slot++;
      end
      if (vid_ack === 1'b1) acks++;
      if (m_vack) vid_addr = 22'($urandom);
    end
    n_checks++;
    if (slot != 100 || acks != 98) begin
      n_errors++;
      $display("FAIL refresh_acks slots=%0d acks=%0d want slots=100 acks=98", slot, acks);
    end
    vid_req = 1'b0;
  endtask

  task automatic test_mem_ready();
    obs_t o, e;
    int activity;
    do_reset();
    mem_ready = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = {1'b0, 21'($urandom)};
    vid_req = 1'b1; vid_addr = {1'b1, 21'($urandom)};
    activity = 0;
    repeat (24) begin
      tick();
      o = dut_obs(); e = ref_obs();
      n_checks++;
      if (o !== e) begin
        n_errors++;
        $display("FAIL not_ready_model cyc=%0d got=%h want=%h", cyc, o, e);
      end
      if (mem_oe || mem_we || cpu_ack || vid_ack) activity++;
    end
    n_checks++;
    if (activity != 0) begin
      n_errors++;
      $display("FAIL not_ready_idle active_cycles=%0d want 0", activity);
    end
    goto_phase(4);
    mem_ready = 1'b1;
    activity = 0;
    while (m_phase != 2) begin
      tick();
      if (m_phase != 2 && (mem_oe || mem_we)) activity++;
    end
    n_checks++;
    if (activity != 0 || mem_oe !== 1'b1 || mem_addr[21] !== 1'b1) begin
      n_errors++;
      $display("FAIL ready_first_grant early=%0d oe=%b vid=%b want early=0 oe=1 vid=1",
               activity, mem_oe, mem_addr[21]);
    end
    repeat (16) begin
      tick();
      o = dut_obs(); e = ref_obs();
      n_checks++;
      if (o !== e) begin
        n_errors++;
        $display("FAIL ready_drain cyc=%0d got=%h want=%h", cyc, o, e);
      end
      if (m_cack) cpu_req = 1'b0;
      if (m_vack) vid_req = 1'b0;
    end
  endtask

  task automatic test_reset_mid_slot();
    obs_t o, e;
    goto_phase(0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 22'($urandom);
    while (m_phase != 4) begin
      tick();
      o = dut_obs(); e = ref_obs();
      n_checks++;
      if (o !== e) begin
        n_errors++;
        $display("FAIL mid_reset_pre cyc=%0d got=%h want=%h", cyc, o, e);
      end
    end
    reset_n = 1'b0;
    tick();
    cpu_req = 1'b0;
    o = dut_obs();
    n_checks++;
    if (o !== reset_obs()) begin
      n_errors++;
      $display("FAIL mid_reset_values got=%h want=%h", o, reset_obs());
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_checks++;
      if (mem_phase !== 3'(k % 8) || cpu_ack !== 1'b0 || mem_oe !== 1'b0) begin
        n_errors++;
        $display("FAIL mid_reset_restart k=%0d phase=%0d ack=%b oe=%b want phase=%0d ack=0 oe=0",
                 k, mem_phase, cpu_ack, mem_oe, k % 8);
      end
    end
  endtask

  task automatic test_random();
    obs_t o, e;
    do_reset();
    repeat (600) begin
      if (m_cack) cpu_req = 1'b0;
      else if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom); cpu_addr = 22'($urandom);
        cpu_din = 16'($urandom); cpu_ds = 2'($urandom);
      end
      if (m_vack) vid_req = 1'b0;
      else if (!vid_req && $urandom_range(0, 1) == 0) begin
        vid_req = 1'b1; vid_addr = 22'($urandom);
      end
      mem_ready = ($urandom_range(0, 19) != 0);
      tick();
      o = dut_obs(); e = ref_obs();
      n_checks++;
      if (o !== e) begin
        n_errors++;
        $display("FAIL random_traffic cyc=%0d got=%h want=%h", cyc, o, e);
      end
    end
    cpu_req = 1'b0; vid_req = 1'b0; mem_ready = 1'b1;
  endtask

  initial begin
    #(32 * 20000);
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    cpu_ds = 2'b11; vid_req = 1'b0; vid_addr = '0; mem_ready = 1'b1;
    use_fixed = 1'b0; fixed_dout = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_contested();
    test_refresh();
    test_mem_ready();
    test_reset_mid_slot();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
